// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: widths, ALU opcode encoding,
// multiplier FSM states and the EX/MEM pipeline register layout.
package ex_pkg;

  localparam int DATA_W = 24;
  localparam int REG_W  = 4;
  localparam int OP_W   = 4;
  // Counter must hold DATA_W-1 (iterations remaining after the first).
  localparam int CNT_W  = $clog2(DATA_W);

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_MUL   = 4'd8,
    OP_SLT   = 4'd9,
    OP_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ex_state_t;

  typedef struct packed {
    logic              valid;
    logic              mem_we;
    logic              reg_we;
    logic              wr_from_alu;
    logic [DATA_W-1:0] data_to_write;
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  reg_to_write;
  } ex_mem_t;

endpackage

// File: rtl/execute_stage_alu_comb.sv
// Purely combinational single-cycle ALU.
// Ports:
//   op_i  - raw opcode (11-15 and MUL produce 0; MUL is done iteratively upstream)
//   a_i   - operand A
//   b_i   - operand B / shift amount in b_i[4:0]
//   res_o - result
module alu_comb
  import ex_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  localparam logic [4:0] SH_LIM = 5'(DATA_W);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:   res_o = a_i + b_i;
      OP_SUB:   res_o = a_i - b_i;
      OP_AND:   res_o = a_i & b_i;
      OP_OR:    res_o = a_i | b_i;
      OP_XOR:   res_o = a_i ^ b_i;
      // A 5-bit amount can exceed the datapath width; clamp explicitly.
      OP_SLL:   res_o = (shamt >= SH_LIM) ? '0 : (a_i << shamt);
      OP_SRL:   res_o = (shamt >= SH_LIM) ? '0 : (a_i >> shamt);
      OP_SRA:   res_o = (shamt >= SH_LIM) ? {DATA_W{a_i[DATA_W-1]}}
                                          : DATA_W'($signed(a_i) >>> shamt);
      OP_SLT:   res_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_PASSB: res_o = b_i;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add MUL that
// stalls upstream while busy. Owns the EX/MEM register feeding memoryStage.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   validIn, flush        - ID/EX valid, kill in-flight/presented instruction
//   aluOp, srcA, srcB     - operation and operands
//   storeData             - store data passed through to dataToWrite
//   regToWriteIn, memWeIn, regWeIn, writeRegFromAluIn - control passed through
//   stall                 - upstream must hold ID/EX (combinational)
//   validOut, memWe, regWe, writeRegFromAlu, dataToWrite, result, regToWrite
//                         - EX/MEM register outputs
module execute_stage
  import ex_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              validIn,
  input  logic              flush,
  input  logic [OP_W-1:0]   aluOp,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  input  logic [DATA_W-1:0] storeData,
  input  logic [REG_W-1:0]  regToWriteIn,
  input  logic              memWeIn,
  input  logic              regWeIn,
  input  logic              writeRegFromAluIn,
  output logic              stall,
  output logic              validOut,
  output logic              memWe,
  output logic              regWe,
  output logic              writeRegFromAlu,
  output logic [DATA_W-1:0] dataToWrite,
  output logic [DATA_W-1:0] result,
  output logic [REG_W-1:0]  regToWrite
);

  ex_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplr_q, mplr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  ex_mem_t           lat_q, lat_d;   // control latched at MUL issue (result unused)
  ex_mem_t           exm_q, exm_d;   // EX/MEM register

  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] acc_step;
  logic              is_mul;

  alu_comb u_alu (
    .op_i  (aluOp),
    .a_i   (srcA),
    .b_i   (srcB),
    .res_o (alu_res)
  );

  assign is_mul   = (aluOp == OP_MUL);
  assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    lat_d   = lat_q;
    stall   = 1'b0;
    // Default is a bubble: payload fields hold, control bits drop.
    exm_d             = exm_q;
    exm_d.valid       = 1'b0;
    exm_d.mem_we      = 1'b0;
    exm_d.reg_we      = 1'b0;
    exm_d.wr_from_alu = 1'b0;

    if (flush) begin
      // Abandon any partial product; nothing is written.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (validIn) begin
            if (is_mul) begin
              mcand_d             = srcA;
              mplr_d              = srcB;
              acc_d               = '0;
              cnt_d               = CNT_W'(DATA_W - 1);
              lat_d.valid         = 1'b1;
              lat_d.mem_we        = memWeIn;
              lat_d.reg_we        = regWeIn;
              lat_d.wr_from_alu   = writeRegFromAluIn;
              lat_d.data_to_write = storeData;
              lat_d.result        = '0;
              lat_d.reg_to_write  = regToWriteIn;
              state_d             = BUSY;
              stall               = 1'b1;
            end else begin
              exm_d.valid         = 1'b1;
              exm_d.mem_we        = memWeIn;
              exm_d.reg_we        = regWeIn;
              exm_d.wr_from_alu   = writeRegFromAluIn;
              exm_d.data_to_write = storeData;
              exm_d.result        = alu_res;
              exm_d.reg_to_write  = regToWriteIn;
            end
          end
        end
        BUSY: begin
          acc_d   = acc_step;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            // Final iteration: stall drops so upstream advances on this edge.
            exm_d        = lat_q;
            exm_d.valid  = 1'b1;
            exm_d.result = acc_step;
            state_d      = IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      lat_q   <= '0;
      exm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      lat_q   <= lat_d;
      exm_q   <= exm_d;
    end
  end

  assign validOut        = exm_q.valid;
  assign memWe           = exm_q.mem_we;
  assign regWe           = exm_q.reg_we;
  assign writeRegFromAlu = exm_q.wr_from_alu;
  assign dataToWrite     = exm_q.data_to_write;
  assign result          = exm_q.result;
  assign regToWrite      = exm_q.reg_to_write;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset, validIn, flush;
  logic [3:0]  aluOp;
  logic [23:0] srcA, srcB, storeData;
  logic [3:0]  regToWriteIn;
  logic        memWeIn, regWeIn, writeRegFromAluIn;
  logic        stall, validOut, memWe, regWe, writeRegFromAlu;
  logic [23:0] dataToWrite, result;
  logic [3:0]  regToWrite;

  int total = 0;
  int bad   = 0;

  // Expected held payload for bubbles.
  logic [23:0] hold_res, hold_dtw;
  logic [3:0]  hold_rd;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk               (clk),
    .reset             (reset),
    .validIn           (validIn),
    .flush             (flush),
    .aluOp             (aluOp),
    .srcA              (srcA),
    .srcB              (srcB),
    .storeData         (storeData),
    .regToWriteIn      (regToWriteIn),
    .memWeIn           (memWeIn),
    .regWeIn           (regWeIn),
    .writeRegFromAluIn (writeRegFromAluIn),
    .stall             (stall),
    .validOut          (validOut),
    .memWe             (memWe),
    .regWe             (regWe),
    .writeRegFromAlu   (writeRegFromAlu),
    .dataToWrite       (dataToWrite),
    .result            (result),
    .regToWrite        (regToWrite)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: plain 64-bit arithmetic then truncation to 24 bits.
  function automatic logic [23:0] model(int op, logic [23:0] a, logic [23:0] b);
    longint ua, ub, sa, sb, r;
    int sh;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[23] ? ua - (longint'(1) << 24) : ua;
    sb = b[23] ? ub - (longint'(1) << 24) : ub;
    sh = int'(b[4:0]);
    case (op)
      0:  r = ua + ub;
      1:  r = ua - ub;
      2:  r = ua & ub;
      3:  r = ua | ub;
      4:  r = ua ^ ub;
      5:  r = ua << sh;
      6:  r = ua >> sh;
      7:  r = sa >>> sh;
      8:  r = ua * ub;
      9:  r = (sa < sb) ? 1 : 0;
      10: r = ub;
      default: r = 0;
    endcase
    return r[23:0];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bubble(string tag);
    chk({tag, "_ctl"}, {validOut, memWe, regWe, writeRegFromAlu}, 4'b0000);
    chk({tag, "_res"}, result, hold_res);
    chk({tag, "_dtw"}, dataToWrite, hold_dtw);
    chk({tag, "_rd"},  regToWrite, hold_rd);
  endtask

  task automatic chk_instr(string tag, logic [23:0] er, logic [23:0] sd, logic [3:0] rd,
                           logic mwe, logic rwe, logic wfa);
    chk({tag, "_ctl"}, {validOut, memWe, regWe, writeRegFromAlu}, {1'b1, mwe, rwe, wfa});
    chk({tag, "_res"}, result, er);
    chk({tag, "_dtw"}, dataToWrite, sd);
    chk({tag, "_rd"},  regToWrite, rd);
    hold_res = er;
    hold_dtw = sd;
    hold_rd  = rd;
  endtask

  task automatic drive(int op, logic [23:0] a, logic [23:0] b, logic [23:0] sd,
                       logic [3:0] rd, logic mwe, logic rwe, logic wfa);
    validIn           = 1'b1;
    flush             = 1'b0;
    aluOp             = 4'(op);
    srcA              = a;
    srcB              = b;
    storeData         = sd;
    regToWriteIn      = rd;
    memWeIn           = mwe;
    regWeIn           = rwe;
    writeRegFromAluIn = wfa;
  endtask

  // While stalled the inputs are don't-care; garbage proves latched copies are used.
  task automatic scramble();
    validIn           = 1'($urandom);
    aluOp             = 4'($urandom);
    srcA              = 24'($urandom);
    srcB              = 24'($urandom);
    storeData         = 24'($urandom);
    regToWriteIn      = 4'($urandom);
    memWeIn           = 1'($urandom);
    regWeIn           = 1'($urandom);
    writeRegFromAluIn = 1'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(string tag);
    validIn = 1'b0;
    flush   = 1'b0;
    step();
    chk_bubble(tag);
  endtask

  // Presents one instruction at a negedge and checks it through completion.
  task automatic run(string tag, int op, logic [23:0] a, logic [23:0] b, logic [23:0] sd,
                     logic [3:0] rd, logic mwe, logic rwe, logic wfa);
    int n;
    logic [23:0] er;
    er = model(op, a, b);
    drive(op, a, b, sd, rd, mwe, rwe, wfa);
    #1;
    if (op != 8) begin
      chk({tag, "_stall"}, stall, 1'b0);
      step();
      chk_instr(tag, er, sd, rd, mwe, rwe, wfa);
    end else begin
      n = stall ? 1 : 0;
      for (int k = 1; k <= 25; k++) begin
        step();
        if (k < 25) begin
          chk_bubble({tag, "_busy"});
          scramble();
          #1;
          if (stall) n++;
        end else begin
          chk_instr(tag, er, sd, rd, mwe, rwe, wfa);
        end
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'd24);
    end
    $display("op=%0d a=%h b=%h -> result=%h valid=%b", op, a, b, result, validOut);
  endtask

  initial begin
    int op, nmul;
    logic [23:0] ra, rb;

    reset = 1'b1;
    validIn = 1'b0; flush = 1'b0; aluOp = '0; srcA = '0; srcB = '0; storeData = '0;
    regToWriteIn = '0; memWeIn = 1'b0; regWeIn = 1'b0; writeRegFromAluIn = 1'b0;
    hold_res = '0; hold_dtw = '0; hold_rd = '0;
    step();
    step();
    chk("reset_out", {validOut, memWe, regWe, writeRegFromAlu, result, dataToWrite, regToWrite},
        '0);
    chk("reset_stall", stall, 1'b0);
    reset = 1'b0;

    // Directed cases
    run("add", 0, 24'h000005, 24'h000003, 24'h000000, 4'd4, 1'b0, 1'b1, 1'b1);
    run("store", 10, 24'h000000, 24'h000100, 24'hABCDEF, 4'd0, 1'b1, 1'b0, 1'b0);
    run("mul7x6", 8, 24'h000007, 24'h000006, 24'h000000, 4'd3, 1'b0, 1'b1, 1'b1);
    chk("mul7x6_value", result, 24'h00002A);
    run("mul_trunc", 8, 24'h800000, 24'h000002, 24'h000000, 4'd5, 1'b0, 1'b1, 1'b1);
    chk("mul_trunc_value", result, 24'h000000);
    run("sra30", 7, 24'h800000, 24'd30, 24'h000000, 4'd6, 1'b0, 1'b1, 1'b1);
    chk("sra30_value", result, 24'hFFFFFF);
    run("sub", 1, 24'h000000, 24'h000001, 24'h000000, 4'd7, 1'b0, 1'b1, 1'b1);
    chk("sub_value", result, 24'hFFFFFF);
    run("sll24", 5, 24'h123456, 24'd24, 24'h000000, 4'd1, 1'b0, 1'b1, 1'b1);
    run("srl3", 6, 24'hF00000, 24'd3, 24'h000000, 4'd1, 1'b0, 1'b1, 1'b1);
    run("slt", 9, 24'hFFFFFF, 24'h000001, 24'h000000, 4'd2, 1'b0, 1'b1, 1'b1);
    run("op13", 13, 24'h111111, 24'h222222, 24'h333333, 4'd9, 1'b1, 1'b1, 1'b0);
    idle("idle0");

    // Flush on the 10th BUSY cycle
    drive(8, 24'h000005, 24'h000009, 24'h000000, 4'd8, 1'b0, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 9; i++) begin
      scramble();
      step();
    end
    validIn = 1'b0;
    flush   = 1'b1;
    #1;
    chk("flush_stall_same", stall, 1'b0);
    step();
    flush = 1'b0;
    chk_bubble("flush_next");
    #1;
    chk("flush_stall_next", stall, 1'b0);
    for (int i = 0; i < 16; i++) idle("flush_nomul");
    run("add_after_flush", 0, 24'h000010, 24'h000020, 24'h000000, 4'd2, 1'b0, 1'b1, 1'b1);

    // Flush against a freshly presented instruction
    drive(8, 24'h000003, 24'h000003, 24'h000000, 4'd2, 1'b0, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_idle_mul_stall", stall, 1'b0);
    step();
    chk_bubble("flush_idle_mul");
    drive(0, 24'h000001, 24'h000001, 24'h000000, 4'd3, 1'b0, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    chk_bubble("flush_idle_add");
    idle("flush_idle_after");

    // Reset mid-MUL
    drive(8, 24'h000abc, 24'h000123, 24'h000000, 4'd1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    validIn = 1'b0;
    #1;
    chk("reset_mid_out", {validOut, memWe, regWe, writeRegFromAlu, result, dataToWrite, regToWrite},
        '0);
    chk("reset_mid_stall", stall, 1'b0);
    hold_res = '0; hold_dtw = '0; hold_rd = '0;
    for (int i = 0; i < 20; i++) idle("reset_nomul");

    // Back-to-back MUL then ADD: ADD lands exactly one edge after the MUL result
    run("b2b_mul", 8, 24'h001234, 24'h000056, 24'h000000, 4'd10, 1'b0, 1'b1, 1'b1);
    run("b2b_add", 0, 24'h0000FF, 24'h000001, 24'h000000, 4'd11, 1'b0, 1'b1, 1'b1);

    // Randomized traffic against the model
    nmul = 0;
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 15));
      if (op == 8) begin
        if (nmul >= 6) op = 0;
        else nmul++;
      end
      ra = 24'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 31)) : 24'($urandom);
      run("rand", op, ra, rb, 24'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom));
      if ($urandom_range(0, 3) == 0) idle("rand_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
